// File: rtl/ysyx_22040759_ifu_pkg.sv
// Purpose: shared definitions for the IFU: reset fetch address and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_22040759_ifu_pkg;

    // First fetch address after reset.
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    // IFU control states. IDLE is only reachable through reset.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040759_ifu.sv
// Purpose: instruction fetch unit; issues one fetch at a time, buffers one instruction for decode.
// Latency: request accepted in cycle N, response in N+1, instruction valid to decode in N+2.
// Backpressure: holds ireq_addr until ireq_ready; holds if_pc/if_inst until if_ready or a redirect.
//
// Ports:
//   clock, reset               single clock, asynchronous active-high reset
//   br_taken, bru_pc           one-cycle redirect request and its target
//   ireq_valid/ready/addr      fetch request channel to memory
//   irsp_valid, irsp_data      fetch response channel (in order, one per accepted request)
//   if_valid/ready/pc/inst     instruction channel to decode
module ysyx_22040759_ifu
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [63:0] bru_pc,
    output logic        ireq_valid,
    input  logic        ireq_ready,
    output logic [63:0] ireq_addr,
    input  logic        irsp_valid,
    input  logic [31:0] irsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst
);

    ifu_state_e  state_q,   state_d;
    logic [63:0] pc_q,      pc_d;       // next PC to fetch
    logic [63:0] addr_q,    addr_d;     // address of the request currently presented
    logic        drop_q,    drop_d;     // outstanding fetch was overtaken by a redirect
    logic [63:0] if_pc_q,   if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A redirect cannot retract a presented request; mark its
                // response stale instead and keep ireq_addr stable.
                if (br_taken) begin
                    pc_d   = bru_pc;
                    drop_d = 1'b1;
                end
                if (ireq_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (irsp_valid) begin
                    if (drop_q || br_taken) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (br_taken) begin
                            pc_d = bru_pc;
                        end
                    end else begin
                        if_inst_d = irsp_data;
                        if_pc_d   = pc_q;
                        pc_d      = pc_q + 64'd4;
                        state_d   = S_HOLD;
                    end
                end else if (br_taken) begin
                    pc_d   = bru_pc;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over a decode handshake in the same cycle.
                if (br_taken) begin
                    pc_d    = bru_pc;
                    state_d = S_REQ;
                end else if (if_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latch the request address once, on entry to REQ.
        if ((state_q != S_REQ) && (state_d == S_REQ)) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            drop_q    <= 1'b0;
            if_pc_q   <= 64'd0;
            if_inst_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            drop_q    <= drop_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    assign ireq_valid = (state_q == S_REQ);
    assign ireq_addr  = addr_q;
    assign if_valid   = (state_q == S_HOLD) && !br_taken;
    assign if_pc      = if_pc_q;
    assign if_inst    = if_inst_q;

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
module tb_ysyx_22040759_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clock;
    logic        reset;
    logic        br_taken;
    logic [63:0] bru_pc;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [63:0] ireq_addr;
    logic        irsp_valid;
    logic [31:0] irsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    ysyx_22040759_ifu #(.RESET_PC(RST_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .br_taken   (br_taken),
        .bru_pc     (bru_pc),
        .ireq_valid (ireq_valid),
        .ireq_ready (ireq_ready),
        .ireq_addr  (ireq_addr),
        .irsp_valid (irsp_valid),
        .irsp_data  (irsp_data),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: a fetch is tagged with the redirect epoch at issue time;
    // its response is usable only if no redirect has happened since.
    logic        m_boot;
    logic        m_fetching;
    logic        m_waiting;
    logic        m_holding;
    logic [63:0] m_next;
    logic [63:0] m_req_addr;
    int          m_epoch;
    int          m_req_epoch;
    logic [63:0] m_hold_pc;
    logic [31:0] m_hold_inst;

    function automatic logic [31:0] rsp_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot      = 1'b1;
        m_fetching  = 1'b0;
        m_waiting   = 1'b0;
        m_holding   = 1'b0;
        m_next      = RST_PC;
        m_req_addr  = RST_PC;
        m_epoch     = 0;
        m_req_epoch = 0;
        m_hold_pc   = 64'd0;
        m_hold_inst = 32'd0;
    endtask

    task automatic model_issue();
        m_fetching  = 1'b1;
        m_req_addr  = m_next;
        m_req_epoch = m_epoch;
    endtask

    task automatic model_step(input logic br, input logic [63:0] bru, input logic rdy,
                              input logic rsp, input logic ifr, input logic [31:0] dat);
        if (m_boot) begin
            m_boot = 1'b0;
            model_issue();
        end else if (m_fetching) begin
            if (br) begin m_epoch++; m_next = bru; end
            if (rdy) begin m_fetching = 1'b0; m_waiting = 1'b1; end
        end else if (m_waiting) begin
            if (rsp) begin
                m_waiting = 1'b0;
                if (br) begin m_epoch++; m_next = bru; end
                if (!br && m_req_epoch == m_epoch) begin
                    m_holding   = 1'b1;
                    m_hold_pc   = m_req_addr;
                    m_hold_inst = dat;
                    m_next      = m_req_addr + 64'd4;
                end else begin
                    model_issue();
                end
            end else if (br) begin
                m_epoch++;
                m_next = bru;
            end
        end else if (m_holding) begin
            if (br) begin
                m_holding = 1'b0;
                m_next    = bru;
                model_issue();
            end else if (ifr) begin
                m_holding = 1'b0;
                model_issue();
            end
        end
    endtask

    // Called at posedge+1: drive, check settled outputs, clock, advance model.
    task automatic step(input logic br, input logic [63:0] bru, input logic rdy,
                        input logic rsp, input logic ifr);
        br_taken   = br;
        bru_pc     = bru;
        ireq_ready = rdy;
        irsp_valid = rsp;
        irsp_data  = rsp_word(m_req_addr);
        if_ready   = ifr;
        #2;
        chk1("ireq_valid", ireq_valid, m_fetching);
        if (m_fetching) chk64("ireq_addr", ireq_addr, m_req_addr);
        chk1("if_valid", if_valid, m_holding && !br);
        if (m_holding) begin
            chk64("if_pc", if_pc, m_hold_pc);
            chk64("if_inst", {32'd0, if_inst}, {32'd0, m_hold_inst});
        end
        @(posedge clock);
        #1;
        model_step(br, bru, rdy, rsp, ifr, irsp_data);
    endtask

    task automatic do_reset(input logic mid_run, input logic rsp_pulse);
        reset      = 1'b1;
        br_taken   = 1'b0;
        ireq_ready = 1'b0;
        irsp_valid = rsp_pulse;
        if_ready   = 1'b0;
        model_reset();
        if (mid_run) begin
            #1;
            chk1("rst_async_ireq_valid", ireq_valid, 1'b0);
            chk1("rst_async_if_valid", if_valid, 1'b0);
        end
        repeat (2) @(posedge clock);
        #1;
        chk1("rst_ireq_valid", ireq_valid, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk64("rst_ireq_addr", ireq_addr, RST_PC);
        chk64("rst_if_pc", if_pc, 64'd0);
        chk64("rst_if_inst", {32'd0, if_inst}, 64'd0);
        reset      = 1'b0;
        irsp_valid = 1'b0;
    endtask

    // From REQ: handshake, response, decode accept; checks the fetched PC.
    task automatic fetch_once(input string tag, input logic [63:0] addr);
        chk64(tag, ireq_addr, addr);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk1("lat_if_valid", if_valid, 1'b1);
        chk64("lat_if_pc", if_pc, addr);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic        br, rdy, rsp, ifr;
        logic [63:0] bru;

        reset = 1'b1; br_taken = 1'b0; bru_pc = 64'd0; ireq_ready = 1'b0;
        irsp_valid = 1'b0; irsp_data = 32'd0; if_ready = 1'b0;
        do_reset(1'b0, 1'b0);

        // Sequential fetch stream
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);           // IDLE -> REQ
        fetch_once("seq0", 64'h8000_0000);
        fetch_once("seq1", 64'h8000_0004);
        fetch_once("seq2", 64'h8000_0008);

        // Redirect while request stalled: address held, response dropped
        chk64("stall_addr", ireq_addr, 64'h8000_000C);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk64("stall_addr_held", ireq_addr, 64'h8000_000C);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);           // stale response
        chk1("drop_no_valid", if_valid, 1'b0);
        chk64("redir_addr", ireq_addr, 64'h8000_1000);

        // Decode stall then redirect from HOLD
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk64("hold_pc", if_pc, 64'h8000_1000);
        step(1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b1);
        chk64("hold_redir_addr", ireq_addr, 64'h8000_2000);

        // Redirect coincident with the response
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h8000_3000, 1'b0, 1'b1, 1'b1);
        chk1("coinc_no_valid", if_valid, 1'b0);
        chk64("coinc_addr", ireq_addr, 64'h8000_3000);

        // Wrap of pc+4
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        fetch_once("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
        chk64("wrap_addr", ireq_addr, 64'd0);

        // Reset while waiting for a response, with responses around it
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);           // IDLE, stray response
        chk64("post_rst_addr", ireq_addr, RST_PC);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);           // REQ, stray response
        chk1("post_rst_no_valid", if_valid, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            br  = ($urandom % 8) == 0;
            bru = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            if (($urandom % 6) == 0) bru = 64'hFFFF_FFFF_FFFF_FFF8;
            rdy = ($urandom % 3) != 0;
            rsp = m_waiting ? (($urandom % 2) == 0) : (($urandom % 10) == 0);
            ifr = ($urandom % 2) == 0;
            if (($urandom % 600) == 0) begin
                do_reset(1'b1, rsp);
            end else begin
                step(br, bru, rdy, rsp, ifr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
